spmmio_uart_bridge: RTL and testbench



---
 rtl/spmmio_uart_bridge_pkg.sv | 42 ++++
 rtl/spmmio_uart_bridge_rx.sv | 110 +++++++++++
 rtl/spmmio_uart_bridge.sv | 265 ++++++++++++++++++++++++++
 tb/tb_spmmio_uart_bridge.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmmio_uart_bridge_pkg.sv
// Shared definitions for the UART-to-spmmio debug bridge: parser and
// receiver state encodings, response byte values, command byte field
// positions and the inter-byte timeout multiplier.
package spmmio_uart_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA0,
    ST_DATA1,
    ST_DATA2,
    ST_DATA3,
    ST_BUS,
    ST_RESP
  } parser_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam int unsigned CMD_WE_BIT  = 7;
  localparam int unsigned CMD_RSV_MSB = 6;
  localparam int unsigned CMD_RSV_LSB = 4;
  localparam int unsigned CMD_SEL_MSB = 3;
  localparam int unsigned CMD_SEL_LSB = 0;

  localparam int unsigned TIMEOUT_BIT_PERIODS = 32;

  // True while a packet is partially received (header seen, bus cycle not yet issued).
  function automatic logic in_packet(input parser_state_e s);
    return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_DATA0) ||
           (s == ST_DATA1) || (s == ST_DATA2) || (s == ST_DATA3);
  endfunction

endpackage

// File: rtl/spmmio_uart_bridge_rx.sv
// 8N1 serial receiver for the spmmio UART bridge.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   rxd         : raw serial input, idle high (synchronised here, 2 flops)
//   rx_byte     : last received byte, valid while rx_valid pulses
//   rx_valid    : 1-clk pulse, byte received with a good stop bit
//   rx_ferr     : 1-clk pulse, stop bit sampled low (byte discarded)
module spmmio_uart_bridge_rx
  import spmmio_uart_bridge_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd867
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  rx_state_e   state_q, state_d;
  logic        meta_q, meta_d;
  logic        sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    meta_d  = rxd;
    sync_d  = meta_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync_q) begin
          cnt_d   = BAUD_DIV >> 1;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (sync_q) begin
          // Line went back high by mid-start: treat as a glitch.
          state_d = RX_IDLE;
        end else begin
          cnt_d   = BAUD_DIV;
          bit_d   = '0;
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          sh_d  = {sync_q, sh_q[7:1]};
          cnt_d = BAUD_DIV;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          valid_d = sync_q;
          ferr_d  = !sync_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte  = sh_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/spmmio_uart_bridge.sv
// UART-to-spmmio debug bridge: parses serial command packets
// (cmd, addr_hi, addr_lo[, 4 data bytes]), issues a single-cycle bus
// read or write, and answers with ACK/NAK or 4 bytes of read data.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   adr [0:ADR_W-1], sel [0:3], we, d [0:31] : bus request, held after cs
//   cs            : one-clk bus strobe per transaction
//   q [0:31]      : read data, sampled at the end of the cs cycle
//   uart_txd      : serial response out, idle high
//   uart_rxd      : serial command in, idle high
// Optional: define SPMMIO_UART_BRIDGE_TIMEOUT_EN to drop partial packets
// after 32 bit periods without a completed byte.
module spmmio_uart_bridge
  import spmmio_uart_bridge_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd867,
  parameter int unsigned ADR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic [0:ADR_W-1] adr,
  output logic             cs,
  output logic [0:3]       sel,
  output logic             we,
  output logic [0:31]      d,
  input  logic [0:31]      q,
  output logic             uart_txd,
  input  logic             uart_rxd
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  spmmio_uart_bridge_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .rxd     (uart_rxd),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr)
  );

  parser_state_e    state_q, state_d;
  logic             cmd_we_q, cmd_we_d;
  logic [3:0]       cmd_sel_q, cmd_sel_d;
  logic [15:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic [31:0]      d_q, d_d;
  logic [23:0]      resp_q, resp_d;
  logic [1:0]       resp_left_q, resp_left_d;
  logic             txd_q, txd_d;
  logic [8:0]       tx_sh_q, tx_sh_d;
  logic [3:0]       tx_bits_q, tx_bits_d;
  logic [15:0]      tx_cnt_q, tx_cnt_d;

  logic             tx_load;
  logic [7:0]       tx_byte;
  logic             tx_done;
  logic             load_bus;

`ifdef SPMMIO_UART_BRIDGE_TIMEOUT_EN
  localparam logic [21:0] TMO_LAST =
    22'(TIMEOUT_BIT_PERIODS * (int'(BAUD_DIV) + 1) - 1);
  logic [21:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_sel_d   = cmd_sel_q;
    addr_d      = addr_q;
    data_d      = data_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    we_d        = we_q;
    d_d         = d_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    txd_d       = txd_q;
    tx_sh_d     = tx_sh_q;
    tx_bits_d   = tx_bits_q;
    tx_cnt_d    = tx_cnt_q;
    tx_load     = 1'b0;
    tx_byte     = '0;
    load_bus    = 1'b0;

    // tx_bits_q counts periods already started: 0 = start, 1..8 = data, 9 = stop.
    tx_done = (state_q == ST_RESP) && (tx_cnt_q == '0) && (tx_bits_q == 4'd9);

    if ((state_q == ST_RESP) && !tx_done) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_d = tx_cnt_q - 16'd1;
      end else begin
        txd_d     = tx_sh_q[0];
        tx_sh_d   = {1'b1, tx_sh_q[8:1]};
        tx_bits_d = tx_bits_q + 4'd1;
        tx_cnt_d  = BAUD_DIV;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_byte[CMD_RSV_MSB:CMD_RSV_LSB] != '0) begin
            tx_load     = 1'b1;
            tx_byte     = NAK_BYTE;
            resp_left_d = '0;
            state_d     = ST_RESP;
          end else begin
            cmd_we_d  = rx_byte[CMD_WE_BIT];
            cmd_sel_d = rx_byte[CMD_SEL_MSB:CMD_SEL_LSB];
            state_d   = ST_ADDR_HI;
          end
        end
      end
      ST_ADDR_HI: begin
        if (rx_valid) begin
          addr_d  = {rx_byte, addr_q[7:0]};
          state_d = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (rx_valid) begin
          addr_d = {addr_q[15:8], rx_byte};
          if (cmd_we_q) begin
            state_d = ST_DATA0;
          end else begin
            load_bus = 1'b1;
            state_d  = ST_BUS;
          end
        end
      end
      ST_DATA0, ST_DATA1, ST_DATA2: begin
        if (rx_valid) begin
          data_d  = {data_q[23:0], rx_byte};
          state_d = (state_q == ST_DATA0) ? ST_DATA1 :
                    (state_q == ST_DATA1) ? ST_DATA2 : ST_DATA3;
        end
      end
      ST_DATA3: begin
        if (rx_valid) begin
          data_d   = {data_q[23:0], rx_byte};
          load_bus = 1'b1;
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        tx_load = 1'b1;
        state_d = ST_RESP;
        if (we_q) begin
          tx_byte     = ACK_BYTE;
          resp_left_d = '0;
        end else begin
          tx_byte     = q[0:7];
          resp_d      = q[8:31];
          resp_left_d = 2'd3;
        end
      end
      ST_RESP: begin
        if (tx_done) begin
          if (resp_left_q != '0) begin
            tx_load     = 1'b1;
            tx_byte     = resp_q[23:16];
            resp_d      = {resp_q[15:0], 8'h00};
            resp_left_d = resp_left_q - 2'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rx_ferr && in_packet(state_q)) begin
      state_d = ST_IDLE;
    end

`ifdef SPMMIO_UART_BRIDGE_TIMEOUT_EN
    tmo_d = '0;
    if (in_packet(state_q) && !rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 22'd1;
      end
    end
`endif

    // Bus outputs load only on entry to BUS so they stay stable while the
    // next packet is being parsed.
    if (load_bus) begin
      adr_d = addr_d[ADR_W-1:0];
      sel_d = cmd_sel_q;
      we_d  = cmd_we_q;
      if (cmd_we_q) begin
        d_d = data_d;
      end
    end

    if (tx_load) begin
      tx_sh_d   = {1'b1, tx_byte};
      txd_d     = 1'b0;
      tx_bits_d = '0;
      tx_cnt_d  = BAUD_DIV;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_we_q    <= 1'b0;
      cmd_sel_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      adr_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      d_q         <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      txd_q       <= 1'b1;
      tx_sh_q     <= '1;
      tx_bits_q   <= '0;
      tx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_sel_q   <= cmd_sel_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      d_q         <= d_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      txd_q       <= txd_d;
      tx_sh_q     <= tx_sh_d;
      tx_bits_q   <= tx_bits_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

`ifdef SPMMIO_UART_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign adr      = adr_q;
  assign sel      = sel_q;
  assign we       = we_q;
  assign d        = d_q;
  assign cs       = (state_q == ST_BUS);
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_spmmio_uart_bridge.sv
// Self-checking bench for spmmio_uart_bridge (BAUD_DIV=3, ADR_W=8).
module tb_spmmio_uart_bridge;

  localparam logic [15:0] BAUD_DIV = 16'd3;
  localparam int unsigned ADR_W    = 8;
  localparam int          BIT_CLKS = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [0:ADR_W-1] adr;
  logic             cs;
  logic [0:3]       sel;
  logic             we;
  logic [0:31]      d;
  logic [0:31]      q;
  logic             uart_txd;
  logic             uart_rxd;

  always #5 clk = ~clk;

  spmmio_uart_bridge #(.BAUD_DIV(BAUD_DIV), .ADR_W(ADR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .adr     (adr),
    .cs      (cs),
    .sel     (sel),
    .we      (we),
    .d       (d),
    .q       (q),
    .uart_txd(uart_txd),
    .uart_rxd(uart_rxd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Bus monitor: counts strobes and captures the request on each one.
  int         cs_count = 0;
  logic [0:7] mon_adr;
  logic [0:3] mon_sel;
  logic       mon_we;
  logic [0:31] mon_d;
  logic       mon_txd_after;
  logic       cs_prev = 1'b0;

  always @(negedge clk) begin
    if (cs_prev) mon_txd_after = uart_txd;
    if (cs === 1'b1) begin
      cs_count++;
      mon_adr = adr;
      mon_sel = sel;
      mon_we  = we;
      mon_d   = d;
    end
    cs_prev = (cs === 1'b1);
  end

  // Serial decoder for uart_txd; bytes interrupted by reset are dropped.
  logic [7:0] txq[$];
  int         tx_ferr = 0;
  logic [7:0] dec_b;
  bit         dec_ok;
  logic       dec_stop;

  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && uart_txd === 1'b0) begin
        dec_ok = 1'b1;
        dec_b  = '0;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          if (reset !== 1'b0) dec_ok = 1'b0;
        end
        if (uart_txd !== 1'b0) dec_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < BIT_CLKS; k++) begin
            @(negedge clk);
            if (reset !== 1'b0) dec_ok = 1'b0;
          end
          dec_b[i] = uart_txd;
        end
        for (int k = 0; k < BIT_CLKS; k++) begin
          @(negedge clk);
          if (reset !== 1'b0) dec_ok = 1'b0;
        end
        dec_stop = uart_txd;
        if (dec_ok) begin
          txq.push_back(dec_b);
          if (dec_stop !== 1'b1) tx_ferr++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  // Sends one packet and checks it against the packet rules: a reserved
  // field != 0 means a lone NAK; otherwise one bus cycle, then ACK or q bytes.
  task automatic do_txn(input string tag, input logic [7:0] c, input logic [15:0] a,
                        input logic [0:31] wdata, input logic [0:31] qv);
    logic [7:0]  pkt[$];
    logic [7:0]  exp_resp[$];
    bit          exp_bus;
    logic [0:3]  exp_sel;
    logic [0:7]  exp_adr;
    int          cs0;
    int          fe0;

    exp_bus = (c[6:4] == 3'b000);
    pkt.push_back(c);
    if (!exp_bus) begin
      exp_resp.push_back(8'h15);
    end else begin
      pkt.push_back(a[15:8]);
      pkt.push_back(a[7:0]);
      for (int i = 0; i < 4; i++) exp_sel[i] = c[3 - i];
      exp_adr = a[ADR_W-1:0];
      if (c[7]) begin
        for (int k = 0; k < 4; k++) pkt.push_back(wdata[8*k +: 8]);
        exp_resp.push_back(8'h06);
      end else begin
        for (int k = 0; k < 4; k++) exp_resp.push_back(qv[8*k +: 8]);
      end
    end

    q   = qv;
    cs0 = cs_count;
    fe0 = tx_ferr;
    txq.delete();
    foreach (pkt[i]) send_byte(pkt[i], 1'b1);
    for (int i = 0; i < 2000 && txq.size() < exp_resp.size(); i++) @(negedge clk);
    repeat (60) @(negedge clk);

    n_checks++;
    if (cs_count - cs0 !== (exp_bus ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s cs_pulses: got %0d expected %0d", tag, cs_count - cs0, exp_bus ? 1 : 0);
    end
    if (exp_bus) begin
      n_checks++;
      if (mon_we !== c[7] || mon_sel !== exp_sel || mon_adr !== exp_adr) begin
        n_fail++;
        $display("FAIL %s bus_req: got we=%b sel=%b adr=%h expected we=%b sel=%b adr=%h",
                 tag, mon_we, mon_sel, mon_adr, c[7], exp_sel, exp_adr);
      end
      if (c[7]) begin
        n_checks++;
        if (mon_d !== wdata) begin
          n_fail++;
          $display("FAIL %s wdata: got %h expected %h", tag, mon_d, wdata);
        end
      end
      n_checks++;
      if (mon_txd_after !== 1'b0) begin
        n_fail++;
        $display("FAIL %s start_latency: txd after cs=%b expected 0", tag, mon_txd_after);
      end
      n_checks++;
      if (adr !== exp_adr || sel !== exp_sel || we !== c[7] || (c[7] && d !== wdata)) begin
        n_fail++;
        $display("FAIL %s bus_hold: got adr=%h sel=%b we=%b d=%h", tag, adr, sel, we, d);
      end
    end
    n_checks++;
    if (txq.size() !== exp_resp.size()) begin
      n_fail++;
      $display("FAIL %s resp_len: got %0d expected %0d", tag, txq.size(), exp_resp.size());
    end else begin
      foreach (exp_resp[i]) begin
        n_checks++;
        if (txq[i] !== exp_resp[i]) begin
          n_fail++;
          $display("FAIL %s resp_byte%0d: got %h expected %h", tag, i, txq[i], exp_resp[i]);
        end
      end
    end
    n_checks++;
    if (tx_ferr !== fe0) begin
      n_fail++;
      $display("FAIL %s tx_stop_bit: %0d bad stop bits", tag, tx_ferr - fe0);
    end
    txq.delete();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    uart_rxd = 1'b1;
    q        = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (uart_txd !== 1'b1 || cs !== 1'b0 || we !== 1'b0 || sel !== 4'b0000 ||
        adr !== '0 || d !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got txd=%b cs=%b we=%b sel=%b adr=%h d=%h expected 1 0 0 0 0 0",
               uart_txd, cs, we, sel, adr, d);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write();
    do_txn("write", 8'h8F, 16'h0012, 32'hDEADBEEF, 32'h0);
  endtask

  task automatic test_read();
    do_txn("read", 8'h0C, 16'h0005, 32'h0, 32'h01234567);
  endtask

  task automatic test_nak();
    do_txn("nak", 8'h70, 16'h0, 32'h0, 32'h0);
    do_txn("read_after_nak", 8'h03, 16'h00A7, 32'h0, 32'hCAFEF00D);
  endtask

  task automatic test_framing();
    int cs0;
    cs0 = cs_count;
    txq.delete();
    send_byte(8'h8F, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (100) @(negedge clk);
    n_checks++;
    if (cs_count !== cs0 || txq.size() !== 0) begin
      n_fail++;
      $display("FAIL framing_drop: got %0d cs pulses, %0d resp bytes expected 0 0",
               cs_count - cs0, txq.size());
    end
    do_txn("write_after_ferr", 8'h85, 16'h1234, 32'h11223344, 32'h0);
  endtask

  task automatic test_glitch();
    int cs0;
    cs0 = cs_count;
    txq.delete();
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++;
    if (cs_count !== cs0 || txq.size() !== 0) begin
      n_fail++;
      $display("FAIL glitch_ignored: got %0d cs pulses, %0d resp bytes expected 0 0",
               cs_count - cs0, txq.size());
    end
    do_txn("read_after_glitch", 8'h0F, 16'h00FF, 32'h0, 32'h89ABCDEF);
  endtask

  task automatic test_random();
    logic [7:0]  c;
    logic [15:0] a;
    logic [0:31] wd;
    logic [0:31] qv;
    for (int n = 0; n < 12; n++) begin
      c[7]   = 1'($urandom_range(0, 1));
      c[6:4] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      c[3:0] = 4'($urandom);
      a      = 16'($urandom);
      wd     = $urandom;
      qv     = $urandom;
      do_txn($sformatf("random%0d", n), c, a, wd, qv);
    end
    do_txn("write_sel0", 8'h80, 16'h0042, 32'h5A5AA5A5, 32'h0);
  endtask

  task automatic test_reset_mid_response();
    int cs0;
    int bad;
    logic [0:31] qv;
    qv  = 32'hA1B2C3D4;
    q   = qv;
    cs0 = cs_count;
    txq.delete();
    send_byte(8'h0F, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h21, 1'b1);
    for (int i = 0; i < 2000 && txq.size() < 1; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (uart_txd !== 1'b1 || cs !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: got txd=%b cs=%b expected 1 0", uart_txd, cs);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0 || cs_count - cs0 !== 1) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d low txd samples, %0d cs pulses expected 0 1",
               bad, cs_count - cs0);
    end
    n_checks++;
    if (txq.size() !== 1 || txq[0] !== qv[0:7]) begin
      n_fail++;
      $display("FAIL reset_partial: got %0d bytes expected 1 byte %h", txq.size(), qv[0:7]);
    end
    txq.delete();
    do_txn("read_after_reset", 8'h09, 16'h0077, 32'h0, 32'h0BADBEEF);
  endtask

`ifdef SPMMIO_UART_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int cs0;
    cs0 = cs_count;
    txq.delete();
    send_byte(8'h0F, 1'b1);
    repeat (32 * BIT_CLKS + 16) @(negedge clk);
    n_checks++;
    if (cs_count !== cs0 || txq.size() !== 0) begin
      n_fail++;
      $display("FAIL timeout_silent: got %0d cs pulses, %0d resp bytes expected 0 0",
               cs_count - cs0, txq.size());
    end
    do_txn("write_after_timeout", 8'h8A, 16'h0031, 32'hFEEDFACE, 32'h0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nak();
    test_framing();
    test_glitch();
    test_random();
`ifdef SPMMIO_UART_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_response();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
